// File: rtl/dcf77_decoder.sv
// dcf77_decoder: DCF77 pulse-width decoder that assembles the minute frame and publishes BCD date/time.
// Define DCF77_RANGE_CHECK_EN to additionally reject frames whose decoded fields are out of range.
package dcf77_pkg;
  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [2:0] day_of_week;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } if_date_time;
endpackage

module dcf77_decoder
  import dcf77_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        rx,
  output logic        dcf77_sync,
  output if_date_time dcf77,
  output logic        valid
);
  localparam if_date_time RST_DT = '{year: 8'h00, month: 8'h01, day: 8'h01, day_of_week: 3'd1,
                                     hour: 8'h00, minute: 8'h00, second: 8'h00};
  logic [1:0]  r_meta;
  logic        r_rx_d;
  logic [7:0]  r_hi;
  logic [7:0]  r_lo;
  logic [5:0]  r_idx;
  logic        r_bad;
  logic [58:0] r_bits;
  logic        w_rx;
  logic        w_rise;
  logic        w_fall;
  logic        w_timeout;
  logic        w_mark;
  logic        w_frame_ok;
  logic        w_range_ok;
  logic        w_accept;
  logic        w_unused;
  if_date_time w_dt;
  assign w_rx       = r_meta[1];
  assign w_rise     = w_rx & ~r_rx_d;
  assign w_fall     = ~w_rx & r_rx_d;
  assign w_timeout  = r_lo == 8'd250;
  assign w_mark     = w_rise && r_lo >= 8'd150;
  assign w_unused   = ^r_bits[19:1];
  assign w_dt = '{year: r_bits[57:50], month: {3'b0, r_bits[49:45]}, day: {2'b0, r_bits[41:36]},
                  day_of_week: r_bits[44:42], hour: {2'b0, r_bits[34:29]},
                  minute: {1'b0, r_bits[27:21]}, second: 8'h00};
  assign w_frame_ok = !(r_bad || w_timeout) && r_idx == 6'd59 && !r_bits[0] && r_bits[20] &&
                      !(^r_bits[28:21]) && !(^r_bits[35:29]) && !(^r_bits[58:36]);
`ifdef DCF77_RANGE_CHECK_EN
  assign w_range_ok = w_dt.minute[3:0] <= 4'd9 && w_dt.minute <= 8'h59 &&
                      w_dt.hour[3:0] <= 4'd9 && w_dt.hour <= 8'h23 &&
                      w_dt.day[3:0] <= 4'd9 && w_dt.day >= 8'h01 && w_dt.day <= 8'h31 &&
                      w_dt.month[3:0] <= 4'd9 && w_dt.month >= 8'h01 && w_dt.month <= 8'h12 &&
                      w_dt.year[3:0] <= 4'd9 && w_dt.year[7:4] <= 4'd9 && w_dt.day_of_week != 3'd0;
`else
  assign w_range_ok = 1'b1;
`endif
  assign w_accept   = w_mark && w_frame_ok && w_range_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta     <= '0;
      r_rx_d     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_idx      <= '0;
      r_bad      <= 1'b0;
      r_bits     <= '0;
      dcf77_sync <= 1'b0;
      valid      <= 1'b0;
      dcf77      <= RST_DT;
    end else begin
      r_meta <= {r_meta[0], rx};
      if (clk_en) begin
        r_rx_d     <= w_rx;
        r_hi       <= w_rise ? 8'd1 : (w_rx && r_hi != 8'hff) ? r_hi + 8'd1 : r_hi;
        r_lo       <= w_rx ? 8'd0 : (r_lo != 8'hff) ? r_lo + 8'd1 : r_lo;
        dcf77_sync <= w_accept;
        // A minute mark takes priority over a timeout landing on the same tick
        if (w_mark) begin
          valid <= w_accept;
          r_idx <= '0;
          r_bad <= 1'b0;
          if (w_accept) dcf77 <= w_dt;
        end else if (w_timeout) begin
          r_bad <= 1'b1;
          r_idx <= '0;
        end else if (w_fall) begin
          if (r_idx < 6'd59) r_bits[r_idx] <= r_hi >= 8'd15;
          if (r_idx != 6'd60) r_idx <= r_idx + 6'd1;
          if (r_hi < 8'd5 || r_hi > 8'd25) r_bad <= 1'b1;
        end
      end
    end
  end
endmodule
